// File: rtl/zoom_frame_reader.sv
// Raster-scans a WIDTH x HEIGHT pixel region of dmem and emits it as a valid/ready pixel stream with eol/eof tags.
// Optional frame checksum on the output stream is enabled by defining ZOOM_RD_CHECKSUM_EN.
module zoom_frame_reader #(
  parameter int          ADDR_W    = 32,
  parameter int unsigned BASE_ADDR = 8192,
  parameter int          WIDTH     = 100,
  parameter int          HEIGHT    = 100
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [7:0]        m_data,
  output logic              m_eol,
  output logic              m_eof,
  output logic [15:0]       checksum
);

  localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(HEIGHT - 1);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [COL_W-1:0]  col_reg, col_next;
  logic [ROW_W-1:0]  row_reg, row_next;
  logic              inflight_reg;
  logic [1:0]        tag_reg;
  logic              wr_ptr_reg, rd_ptr_reg;
  logic [1:0]        count_reg, count_next;

  logic       clear;
  logic       issue;
  logic       push;
  logic       pop;
  logic       last_read;
  logic       tag_eol;
  logic       tag_eof;
  logic [9:0] head;
  logic [9:0] entry_q [2];

  assign push      = inflight_reg;
  assign pop       = (count_reg != 2'd0) && m_ready;
  assign tag_eol   = (col_reg == COL_LAST);
  assign tag_eof   = tag_eol && (row_reg == ROW_LAST);
  assign last_read = tag_eof;

  // Occupancy counts reads still in flight so the 2-entry FIFO can never overflow.
  assign issue = (state_reg == S_RUN) &&
                 (({1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, pop}) < 3'd2);

  assign count_next = count_reg + {1'b0, push} - {1'b0, pop};

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    col_next   = col_reg;
    row_next   = row_reg;
    clear      = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_RUN;
          addr_next  = BASE;
          col_next   = '0;
          row_next   = '0;
          clear      = 1'b1;
        end
      end
      S_RUN: begin
        if (issue) begin
          if (last_read) begin
            state_next = S_FLUSH;
          end else begin
            addr_next = addr_reg + ADDR_W'(1);
            if (tag_eol) begin
              col_next = '0;
              row_next = row_reg + ROW_W'(1);
            end else begin
              col_next = col_reg + COL_W'(1);
            end
          end
        end
      end
      S_FLUSH: begin
        // Looking at next-cycle occupancy lets done follow the final handshake directly.
        if (count_next == 2'd0) begin
          state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      addr_reg     <= '0;
      col_reg      <= '0;
      row_reg      <= '0;
      inflight_reg <= 1'b0;
      tag_reg      <= 2'b00;
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
      count_reg    <= 2'd0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      col_reg      <= col_next;
      row_reg      <= row_next;
      inflight_reg <= issue;
      if (issue) begin
        tag_reg <= {tag_eol, tag_eof};
      end
      if (clear) begin
        wr_ptr_reg <= 1'b0;
        rd_ptr_reg <= 1'b0;
        count_reg  <= 2'd0;
      end else begin
        if (push) wr_ptr_reg <= ~wr_ptr_reg;
        if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
        count_reg <= count_next;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      logic [9:0] entry_reg;
      always_ff @(posedge clk) begin
        if (reset) begin
          entry_reg <= '0;
        end else if (push && (wr_ptr_reg == 1'(gi))) begin
          entry_reg <= {tag_reg, mem_rdata};
        end
      end
      assign entry_q[gi] = entry_reg;
    end
  endgenerate

  assign head      = rd_ptr_reg ? entry_q[1] : entry_q[0];
  assign m_valid   = (count_reg != 2'd0);
  assign m_data    = head[7:0];
  assign m_eof     = head[8];
  assign m_eol     = head[9];
  assign busy      = (state_reg == S_RUN) || (state_reg == S_FLUSH);
  assign done      = (state_reg == S_DONE);
  assign mem_rd_en = issue;
  assign mem_addr  = addr_reg;

`ifdef ZOOM_RD_CHECKSUM_EN
  logic [15:0] checksum_reg;
  always_ff @(posedge clk) begin
    if (reset) begin
      checksum_reg <= 16'd0;
    end else if (clear) begin
      checksum_reg <= 16'd0;
    end else if (pop) begin
      checksum_reg <= checksum_reg + {8'd0, m_data};
    end
  end
  assign checksum = checksum_reg;
`else
  assign checksum = 16'd0;
`endif

endmodule

// File: tb/tb_zoom_frame_reader.sv
// Directed bench for zoom_frame_reader: scoreboard of expected pixels, address tracking and handshake timing checks.
module tb_zoom_frame_reader;

  localparam int W    = 100;
  localparam int H    = 100;
  localparam int N    = W * H;
  localparam int BASE = 8192;
  localparam int LIM  = 20000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, mem_rd_en;
  logic [31:0] mem_addr;
  logic [7:0]  mem_rdata = 8'h00;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [7:0]  m_data;
  logic        m_eol, m_eof;
  logic [15:0] checksum;

  logic        start1 = 1'b0;
  logic        busy1, done1, rd_en1;
  logic [31:0] addr1;
  logic [7:0]  rdata1 = 8'h00;
  logic        valid1;
  logic        ready1 = 1'b1;
  logic [7:0]  data1;
  logic        eol1, eof1;
  logic [15:0] cks1;

  zoom_frame_reader #(.ADDR_W(32), .BASE_ADDR(BASE), .WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_eol(m_eol), .m_eof(m_eof), .checksum(checksum)
  );

  zoom_frame_reader #(.ADDR_W(32), .BASE_ADDR(0), .WIDTH(1), .HEIGHT(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1),
    .mem_rd_en(rd_en1), .mem_addr(addr1), .mem_rdata(rdata1),
    .m_valid(valid1), .m_ready(ready1), .m_data(data1),
    .m_eol(eol1), .m_eof(eof1), .checksum(cks1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit [7:0] dmem [N];
  always @(posedge clk) begin
    if (mem_rd_en) begin
      if (mem_addr >= 32'(BASE) && mem_addr < 32'(BASE + N)) mem_rdata <= dmem[mem_addr - 32'(BASE)];
      else mem_rdata <= 8'h00;
    end
  end

  always @(posedge clk) begin
    if (rd_en1) rdata1 <= (addr1 == 32'd0) ? 8'hA5 : 8'h00;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [9:0]  sb_q [$];
  int          pix_cnt, done_cnt, done_cyc, first_cyc, issued, popped, start_cyc;
  logic [31:0] exp_addr;
  logic [15:0] cks_done, exp_cks;
  bit          prev_stall, mon_en;
  logic [7:0]  prev_data;

  // Output monitor: scoreboard pops, read-address tracking, stall stability.
  initial begin
    logic [9:0] exp_pix;
    forever begin
      @(negedge clk);
      if (mon_en && !reset) begin
        if (prev_stall) begin
          check("stall_valid", 32'(m_valid), 32'(1));
          check("stall_data", 32'(m_data), 32'(prev_data));
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        if (mem_rd_en) begin
          check("rd_addr", mem_addr, exp_addr);
          exp_addr++;
          issued++;
        end
        if (m_valid && m_ready) begin
          if (sb_q.size() == 0) begin
            check("sb_extra_pixel", 32'(sb_q.size()), 32'(1));
          end else begin
            exp_pix = sb_q.pop_front();
            check("pixel", 32'({m_eol, m_eof, m_data}), 32'(exp_pix));
          end
          if (pix_cnt == 0) first_cyc = cyc;
          pix_cnt++;
          popped++;
        end
        check("outstanding", 32'((issued - popped) <= 2), 32'(1));
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          cks_done = checksum;
          check("busy_at_done", 32'(busy), 32'(0));
        end
      end
    end
  end

  // Caller is positioned 1 time unit after a rising edge.
  task automatic start_frame();
    sb_q.delete();
    for (int i = 0; i < N; i++) begin
      logic [7:0] v;
      v = dmem[i];
      sb_q.push_back({(i % W) == W - 1, i == N - 1, v});
    end
    pix_cnt = 0; done_cnt = 0; issued = 0; popped = 0;
    done_cyc = -1; first_cyc = -1;
    exp_addr = 32'(BASE);
    prev_stall = 0;
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("start_busy", 32'(busy), 32'(1));
    check("start_rd_en", 32'(mem_rd_en), 32'(1));
    check("start_addr", mem_addr, 32'(BASE));
    check("start_cks_clear", 32'(checksum), 32'(0));
  endtask

  task automatic wait_done(input bit timed);
    bit seen;
    seen = 0;
    for (int i = 0; i < LIM; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    @(posedge clk); #1;
    check("done_seen", 32'(seen), 32'(1));
    if (timed) begin
      check("first_pixel_cycle", 32'(first_cyc), 32'(start_cyc + 3));
      check("done_cycle", 32'(done_cyc), 32'(start_cyc + 3 + N));
    end
    check("pixel_count", 32'(pix_cnt), 32'(N));
    check("sb_empty", 32'(sb_q.size()), 32'(0));
    check("done_count", 32'(done_cnt), 32'(1));
    check("cks_at_done", 32'(cks_done), 32'(exp_cks));
    check("cks_held", 32'(checksum), 32'(exp_cks));
    check("idle_after_done", 32'({busy, done}), 32'(0));
  endtask

  initial begin
    int dcount;
    for (int i = 0; i < N; i++) dmem[i] = 8'(i);
    exp_cks = 16'd0;
`ifdef ZOOM_RD_CHECKSUM_EN
    for (int i = 0; i < N; i++) exp_cks = exp_cks + {8'd0, dmem[i]};
`endif
    mon_en = 0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_rd_en", 32'(mem_rd_en), 32'(0));
    check("rst_addr", mem_addr, 32'(0));
    check("rst_valid", 32'(m_valid), 32'(0));
    check("rst_data", 32'({m_eol, m_eof, m_data}), 32'(0));
    check("rst_cks", 32'(checksum), 32'(0));
    @(posedge clk); #1;
    reset = 1'b0;

    // Single-pixel instance: WIDTH=HEIGHT=1, BASE_ADDR=0
    @(posedge clk); #1;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    @(negedge clk);
    check("p1_rd", 32'({busy1, rd_en1}), 32'(3));
    check("p1_addr", addr1, 32'(0));
    @(negedge clk);
    check("p1_not_valid_yet", 32'(valid1), 32'(0));
    @(negedge clk);
    check("p1_pixel", 32'({valid1, eol1, eof1, data1}), 32'({3'b111, 8'hA5}));
    @(negedge clk);
    check("p1_done", 32'({done1, busy1}), 32'(2));
    @(negedge clk);
    check("p1_done_pulse", 32'(done1), 32'(0));

    // Frame 1: full speed
    mon_en = 1;
    @(posedge clk); #1;
    start_frame();
    wait_done(1);

    // Frame 2: backpressure and an ignored mid-frame start
    start_frame();
    for (int i = 0; i < LIM && pix_cnt < 100; i++) begin
      @(posedge clk); #1;
    end
    check("f2_reach_100", 32'(pix_cnt >= 100), 32'(1));
    begin
      bit pat [9] = '{0, 1, 0, 1, 0, 0, 0, 0, 0};
      for (int i = 0; i < 9; i++) begin
        m_ready = pat[i];
        @(posedge clk); #1;
      end
    end
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_bubble", 32'(m_valid), 32'(1));
    end
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(0);
    repeat (20) @(posedge clk);
    #1;
    check("f2_single_done", 32'(done_cnt), 32'(1));
    check("f2_stays_idle", 32'(busy), 32'(0));

    // Frame 3: reset at pixel 500
    start_frame();
    for (int i = 0; i < LIM && pix_cnt < 500; i++) begin
      @(posedge clk); #1;
    end
    check("f3_reach_500", 32'(pix_cnt), 32'(500));
    reset = 1'b1;
    mon_en = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_valid", 32'(m_valid), 32'(0));
    check("rst_mid_busy", 32'(busy), 32'(0));
    check("rst_mid_cks", 32'(checksum), 32'(0));
    dcount = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) dcount++;
      @(negedge clk);
    end
    check("rst_mid_no_done", 32'(dcount), 32'(0));
    mon_en = 1;

    // Frame 4 then frame 5 back-to-back in the cycle after done
    @(posedge clk); #1;
    start_frame();
    wait_done(1);
    start_frame();
    wait_done(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/zoom_frame_reader.md
# zoom_frame_reader

Streams the zoomed destination frame out of data memory as a pixel stream. It is the read-side counterpart of the zoom kernel's writes: after the CPU fills the destination region, it scans that region in raster order (default base 8192, 100x100 pixels) through the data memory's synchronous read port. It emits one 8-bit pixel per valid/ready handshake, tagged with end-of-line and end-of-frame flags. It sits beside `dmem` in `system` and feeds a display/capture sink in place of the bench's hierarchical memory dump.

## Interface
- `ADDR_W`, 32, memory address width
- `BASE_ADDR`, 8192, word address of pixel (0,0)
- `WIDTH`, 100, pixels per line (>=1)
- `HEIGHT`, 100, lines per frame (>=1)
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  begin one frame; sampled only in IDLE
- `busy`  out  1  high from the cycle after accepted `start` until `done`
- `done`  out  1  one-cycle pulse after the last pixel handshake
- `mem_rd_en`  out  1  read request to dmem
- `mem_addr`  out  ADDR_W  read address
- `mem_rdata`  in  8  read data, valid exactly one cycle after `mem_rd_en`
- `m_valid`  out  1  output pixel valid
- `m_ready`  in  1  sink accepts pixel
- `m_data`  out  8  pixel value
- `m_eol`  out  1  pixel is last in its line (col == WIDTH-1)
- `m_eof`  out  1  pixel is last in frame (implies `m_eol`)
- `checksum`  out  16  frame checksum (see Configuration)

## Operation
- FSM states:
  - IDLE: `start` -> RUN; clear pointers, FIFO and checksum.
  - RUN: issue reads; after read WIDTH*HEIGHT-1 is issued -> FLUSH.
  - FLUSH: no reads; wait until the FIFO is empty and no read is in flight -> DONE.
  - DONE: assert `done` for one cycle -> IDLE.
- Address is a running pointer, starting at BASE_ADDR and incremented by 1 per issued read. Row and column counters (col wraps at WIDTH-1) generate tags only. No multiplier.
- Output FIFO, 2 entries x {eol, eof, data[7:0]}. `m_valid` = FIFO not empty. Head is registered and stays stable while `m_valid && !m_ready`.
- Read issue rule: `mem_rd_en` = RUN && (fifo_count + inflight - pop) < 2, where pop = `m_valid && m_ready` in the same cycle. The in-flight read's tag travels in a 1-stage pipe with it.
- Returned data is pushed the cycle `mem_rdata` is valid. Overflow is impossible by the issue rule, and the verifier asserts it never occurs.
- `start` is ignored while `busy`.
- `reset` mid-frame: return to IDLE, flush the FIFO, drop any in-flight read, and do not pulse `done`.
- Reset values: `busy`=0, `done`=0, `mem_rd_en`=0, `mem_addr`=0, `m_valid`=0, `m_data`=0, `m_eol`=0, `m_eof`=0, `checksum`=0.
- `mem_addr` holds its last value when `mem_rd_en`=0.

## Timing
- `start` sampled high in cycle 0:
  - cycle 1: `busy`=1, `mem_rd_en`=1, `mem_addr`=BASE_ADDR.
  - cycle 2: `mem_rdata` valid.
  - cycle 3: `m_valid`=1.
- With `m_ready` held high: one pixel per cycle, cycles 3 .. 3+N-1 (N = WIDTH*HEIGHT). `done`=1 in cycle 3+N. `busy` falls in the same cycle `done` rises.
- Backpressure: at most 2 pixels buffered. When `m_ready` rises, throughput resumes at 1/cycle the same cycle with no bubble.
- A new `start` is accepted at the earliest in the cycle after `done`.
- WIDTH=HEIGHT=1: a single pixel with `m_eol`=`m_eof`=1.

## Configuration
- `ZOOM_RD_CHECKSUM_EN` defined:
  - `checksum` is a 16-bit wrap-around sum of `m_data` over all handshakes of the current frame.
  - Cleared when `start` is accepted; final value valid in the `done` cycle and held until the next accepted `start` or `reset`.
- Not defined: `checksum` tied to 0 and no adder is inferred.

## Test plan
- Reset then `start`, dmem[8192+i] = i[7:0], `m_ready`=1:
  - 10000 pixels in consecutive cycles, values 0..255 repeating.
  - `m_eol` on every 100th pixel; `m_eof` only on pixel 9999.
  - `done` at cycle 10003; checksum = 10000 pixels of the repeating 0..255 pattern summed mod 65536.
- `m_ready` toggling 1-0-1-0, then held low 5 cycles:
  - no lost or duplicated pixels; `m_data` stable while stalled.
  - never more than 2 reads outstanding beyond consumed pixels.
- `start` pulsed again mid-frame: ignored. The pixel count stays 10000 and there is exactly one `done`.
- `reset` asserted at pixel 500: the next cycle has `m_valid`=0 and `busy`=0, and no `done`. A following `start` streams from address 8192 again.
- Parameters WIDTH=1, HEIGHT=1, BASE_ADDR=0, dmem[0]=8'hA5: one pixel A5 with eol=eof=1, and `done` 4 cycles after `start`.
- Back-to-back frames: `start` in the `done`+1 cycle. The second frame's first `mem_rd_en` is at BASE_ADDR, and the checksum restarts from 0.
